// File: rtl/tt_pin_host_bridge.sv
// Host-side bridge: turns register read/write requests into tt_um byte-strobe pin frames and collects the ack/response.
// Optional even-parity on strobes and acks is enabled with TT_HOST_BRIDGE_PARITY_EN.
module tt_pin_host_bridge #(
    parameter int GAP_CYCLES = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [7:0] pin_ui,
    output logic [7:0] pin_uio,
    input  logic [7:0] pin_uo,
    input  logic [7:0] pin_uio_out,
    input  logic [7:0] pin_uio_oe
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        GAP1 = 3'd2,
        DATA = 3'd3,
        GAP2 = 3'd4,
        WAIT = 3'd5,
        RESP = 3'd6
    } state_e;

    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic       write_q, write_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic [7:0] to_cnt_q, to_cnt_d;
    logic       ack_q, ack_d;
    logic [7:0] uo_q, uo_d;
    logic [7:0] rdata_q, rdata_d;
    logic       err_q, err_d;

    logic       strobe;
    logic       parity_bit;
    logic       unused_pins;

    // Bits of the SoC bidir bus this bridge never looks at.
    assign unused_pins = ^{pin_uio_out[7:1], pin_uio_oe[7:1]};

    // Ack and read data are registered together so rdata always matches the ack that completed the read.
`ifdef TT_HOST_BRIDGE_PARITY_EN
    always_comb begin
        ack_d = pin_uio_out[0] & pin_uio_oe[0] & pin_uio_oe[1] & (pin_uio_out[1] == ^pin_uo);
    end
    assign parity_bit = strobe & (^pin_ui);
`else
    always_comb begin
        ack_d = pin_uio_out[0] & pin_uio_oe[0];
    end
    assign parity_bit = 1'b0;
`endif

    assign uo_d = pin_uo;

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        gap_cnt_d = 4'd0;
        to_cnt_d  = 8'd0;
        rdata_d   = rdata_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (GAP_CYCLES == 0) begin
                    state_d = write_q ? DATA : WAIT;
                end else begin
                    state_d = GAP1;
                end
            end
            GAP1: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = write_q ? DATA : WAIT;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            DATA: begin
                state_d = (GAP_CYCLES == 0) ? WAIT : GAP2;
            end
            GAP2: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = WAIT;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            WAIT: begin
                // Ack is checked before the timeout so a late ack on the final cycle still wins.
                if (ack_q) begin
                    state_d = RESP;
                    rdata_d = write_q ? 8'd0 : uo_q;
                    err_d   = 1'b0;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = RESP;
                    rdata_d = 8'd0;
                    err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            write_q   <= 1'b0;
            addr_q    <= 7'd0;
            wdata_q   <= 8'd0;
            gap_cnt_q <= 4'd0;
            to_cnt_q  <= 8'd0;
            ack_q     <= 1'b0;
            uo_q      <= 8'd0;
            rdata_q   <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            gap_cnt_q <= gap_cnt_d;
            to_cnt_q  <= to_cnt_d;
            ack_q     <= ack_d;
            uo_q      <= uo_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Pin outputs decode straight from state so async reset clears them immediately.
    assign strobe    = (state_q == CMD) || (state_q == DATA);
    assign pin_ui    = (state_q == CMD)  ? {write_q, addr_q} :
                       (state_q == DATA) ? wdata_q : 8'd0;
    assign pin_uio   = {6'd0, parity_bit, strobe};
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_tt_pin_host_bridge.sv
// Directed bench for tt_pin_host_bridge (GAP_CYCLES=1, TIMEOUT=64); parity steps run when TT_HOST_BRIDGE_PARITY_EN is defined.
module tb_tt_pin_host_bridge;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] pin_ui;
    logic [7:0] pin_uio;
    logic [7:0] pin_uo;
    logic [7:0] pin_uio_out;
    logic [7:0] pin_uio_oe;

    int checks   = 0;
    int failures = 0;

    tt_pin_host_bridge #(
        .GAP_CYCLES(1),
        .TIMEOUT(64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .pin_ui     (pin_ui),
        .pin_uio    (pin_uio),
        .pin_uo     (pin_uo),
        .pin_uio_out(pin_uio_out),
        .pin_uio_oe (pin_uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected pin_uio during a strobe of byte b.
    function automatic logic [7:0] strobe_uio(input logic [7:0] b);
`ifdef TT_HOST_BRIDGE_PARITY_EN
        return {6'd0, ^b, 1'b1};
`else
        return {6'd0, 1'b0, 1'b1};
`endif
    endfunction

    // SoC model: valid ack with correct parity for the returned byte.
    task automatic drive_ack(input logic [7:0] uo);
        pin_uo      = uo;
        pin_uio_out = {6'd0, ^uo, 1'b1};
        pin_uio_oe  = 8'h03;
    endtask

    task automatic clear_ack();
        pin_uo      = 8'h00;
        pin_uio_out = 8'h00;
        pin_uio_oe  = 8'h00;
    endtask

    // Called #1 after an edge with the bridge idle; returns in the CMD cycle.
    task automatic accept(input logic wr, input logic [6:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 7'd0;
        req_wdata = 8'd0;
    endtask

    // Counts cycles until rsp_valid, bounded.
    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        bit seen;
        rst_n       = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = 7'd0;
        req_wdata   = 8'd0;
        clear_ack();
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_pin_ui", pin_ui, 0);
        chk("reset_pin_uio", pin_uio, 0);
        rst_n = 1'b1;
        tick();

        // Write addr 0x12 data 0xA5: strobes 0x92, gap, 0xA5, gap, then WAIT.
        accept(1'b1, 7'h12, 8'hA5);
        chk("wr_cmd_ui", pin_ui, 8'h92);
        chk("wr_cmd_uio", pin_uio, strobe_uio(8'h92));
        chk("wr_cmd_ready", req_ready, 0);
        tick();
        chk("wr_gap1_ui", pin_ui, 0);
        chk("wr_gap1_uio", pin_uio, 0);
        tick();
        chk("wr_data_ui", pin_ui, 8'hA5);
        chk("wr_data_uio", pin_uio, strobe_uio(8'hA5));
        tick();
        chk("wr_gap2_ui", pin_ui, 0);
        tick();
        drive_ack(8'h77);
        tick();
        clear_ack();
        chk("wr_wait_no_rsp", rsp_valid, 0);
        tick();
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_err", rsp_err, 0);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        chk("wr_rsp_ready", req_ready, 0);
        tick();
        chk("wr_after_valid", rsp_valid, 0);
        chk("wr_after_ready", req_ready, 1);

        // Read addr 0x05 returning 0x3C.
        accept(1'b0, 7'h05, 8'hFF);
        chk("rd_cmd_ui", pin_ui, 8'h05);
        chk("rd_cmd_uio", pin_uio, strobe_uio(8'h05));
        tick();
        chk("rd_gap_ui", pin_ui, 0);
        tick();
        chk("rd_wait_ui", pin_ui, 0);
        drive_ack(8'h3C);
        tick();
        clear_ack();
        chk("rd_wait_no_rsp", rsp_valid, 0);
        tick();
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_rdata", rsp_rdata, 8'h3C);
        chk("rd_rsp_err", rsp_err, 0);
        tick();
        chk("rd_after_ready", req_ready, 1);

        // Minimum-latency read: ack already registered in the first WAIT cycle.
        accept(1'b0, 7'h40, 8'h00);
        tick();
        drive_ack(8'h5A);
        tick();
        clear_ack();
        chk("min_wait_no_rsp", rsp_valid, 0);
        tick();
        chk("min_rsp_valid", rsp_valid, 1);
        chk("min_rsp_rdata", rsp_rdata, 8'h5A);
        tick();

        // Spurious ack while idle is ignored.
        drive_ack(8'h99);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid || !req_ready) seen = 1'b1;
        end
        clear_ack();
        tick();
        chk("idle_ack_ignored", seen, 0);

        // Timeout: read with no ack; rsp_valid 64 cycles after WAIT entry.
        accept(1'b0, 7'h21, 8'h00);
        tick();
        tick();
        wait_rsp(n);
        chk("to_cycles", n, 64);
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_rdata", rsp_rdata, 0);
        tick();

        // Ack gated off by uio_oe[0]=0: still a timeout.
        accept(1'b0, 7'h22, 8'h00);
        tick();
        tick();
        pin_uo      = 8'h11;
        pin_uio_out = 8'h01;
        pin_uio_oe  = 8'h02;
        wait_rsp(n);
        clear_ack();
        chk("gate_cycles", n, 64);
        chk("gate_rsp_err", rsp_err, 1);
        chk("gate_rsp_rdata", rsp_rdata, 0);
        tick();
        tick();

        // Ack registered exactly in the last timeout cycle: ack wins.
        accept(1'b0, 7'h23, 8'h00);
        tick();
        tick();
        for (int i = 0; i < 64; i++) begin
            if (i == 62) drive_ack(8'h81);
            if (i == 63) clear_ack();
            tick();
        end
        chk("last_rsp_valid", rsp_valid, 1);
        chk("last_rsp_err", rsp_err, 0);
        chk("last_rsp_rdata", rsp_rdata, 8'h81);
        tick();

`ifdef TT_HOST_BRIDGE_PARITY_EN
        // Strobe of 0x07 carries parity 1; response 0x03 with wrong parity bit times out.
        accept(1'b0, 7'h07, 8'h00);
        chk("par_cmd_uio", pin_uio, 8'h03);
        tick();
        tick();
        pin_uo      = 8'h03;
        pin_uio_out = 8'h03;
        pin_uio_oe  = 8'h03;
        wait_rsp(n);
        clear_ack();
        chk("par_bad_cycles", n, 64);
        chk("par_bad_err", rsp_err, 1);
        chk("par_bad_rdata", rsp_rdata, 0);
        tick();
        tick();
        accept(1'b0, 7'h07, 8'h00);
        tick();
        tick();
        pin_uo      = 8'h03;
        pin_uio_out = 8'h01;
        pin_uio_oe  = 8'h03;
        tick();
        clear_ack();
        tick();
        chk("par_ok_valid", rsp_valid, 1);
        chk("par_ok_err", rsp_err, 0);
        chk("par_ok_rdata", rsp_rdata, 8'h03);
        tick();
`endif

        // Reset in the DATA cycle of a write: pins clear asynchronously, no response afterwards.
        accept(1'b1, 7'h33, 8'h0F);
        tick();
        tick();
        chk("rst_data_ui", pin_ui, 8'h0F);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_ui", pin_ui, 0);
        chk("rst_async_uio", pin_uio, 0);
        chk("rst_async_ready", req_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive_ack(8'h44);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        clear_ack();
        chk("rst_no_rsp", seen, 0);
        chk("rst_final_ready", req_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_pin_host_bridge.md
Name: tt_pin_host_bridge

Overview:
- Host-side bridge that turns simple register read/write requests into the byte-strobe pin protocol of the tt_um SoC.
- It drives the SoC's ui_in/uio_in pins and collects the response from uo_out/uio_out/uio_oe.
- Used in FPGA bring-up and in the system-level bench in place of hand-driven pin stimulus.
- One clock domain shared with the SoC.

Parameters:
- GAP_CYCLES, 1, idle cycles inserted after every strobed byte (0..15).
- TIMEOUT, 64, cycles to wait for SoC ack before flagging error (2..255).

Ports:
- clk  in  1  system clock, same clock as the SoC.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  bridge idle; request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  7  SoC register address.
- req_wdata  in  8  write data (ignored on read).
- rsp_valid  out  1  one-cycle pulse: transaction complete.
- rsp_rdata  out  8  read data; 0 for writes and on timeout.
- rsp_err  out  1  valid with rsp_valid; 1 = ack timeout.
- pin_ui  out  8  to SoC ui_in: command/data byte.
- pin_uio  out  8  to SoC uio_in: bit0 = byte strobe, bit1 = parity (optional feature), others 0.
- pin_uo  in  8  from SoC uo_out: read data.
- pin_uio_out  in  8  from SoC uio_out: bit0 = ack.
- pin_uio_oe  in  8  from SoC uio_oe: bit0 must be 1 for ack to count.

Behaviour:
- Reset (async, rst_n low): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, pin_ui=0, pin_uio=0, gap and timeout counters 0.
- Request capture: on acceptance, latch write/addr/wdata; req_ready drops the next cycle and stays 0 until the cycle after rsp_valid.
- Frame format:
  - byte0 = {req_write, req_addr}.
  - Writes add byte1 = wdata.
  - Each byte is held on pin_ui for exactly one cycle with pin_uio[0]=1.
  - pin_ui returns to 0 when not strobing.
- FSM states and transitions:
  - IDLE -> CMD on accept.
  - CMD (strobe byte0, 1 cycle) -> GAP1.
  - GAP1 (GAP_CYCLES cycles, skipped if 0) -> DATA if write, else WAIT.
  - DATA (strobe byte1, 1 cycle) -> GAP2.
  - GAP2 (GAP_CYCLES cycles, skipped if 0) -> WAIT.
  - WAIT -> RESP when ack is seen or the timeout expires.
  - RESP (rsp_valid=1, 1 cycle) -> IDLE.
- Ack detection:
  - ack = pin_uio_out[0] && pin_uio_oe[0], registered once; the registered value is sampled in WAIT.
  - Ack present in the first WAIT cycle completes immediately.
  - Read data: pin_uo is registered alongside ack; rsp_rdata takes that registered value.
- Timeout:
  - Counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT-1 without ack: RESP with rsp_err=1, rsp_rdata=0.
  - Ack and timeout in the same cycle: ack wins, err=0.
- Back-to-back requests: req_ready=1 in the cycle after RESP, so the minimum spacing between transactions is (frame cycles + wait + 2).
- Minimum latency, acceptance to rsp_valid:
  - read: 1 CMD + GAP_CYCLES + 1 WAIT + 1 RESP.
  - write: add 1 + GAP_CYCLES.
- Spurious ack in IDLE/CMD/GAP/DATA: ignored. No state change, no error.
- Reset mid-transaction: immediate return to IDLE and reset values; a partial frame is abandoned with no rsp_valid.
- Counter widths: gap 4 bits, timeout 8 bits. No wrap-around is reachable within the parameter ranges.

Optional Feature:
- Macro: TT_HOST_BRIDGE_PARITY_EN.
- Defined:
  - pin_uio[1] = even parity of pin_ui during every strobe cycle, 0 otherwise.
  - In WAIT, ack additionally requires pin_uio_out[1] == even parity of pin_uo, and only while pin_uio_oe[1]=1.
  - Parity mismatch with ack present: treated as no ack, so it ends in timeout with rsp_err=1.
- Undefined: pin_uio[1] is constant 0; pin_uio_out[1] and pin_uio_oe[1] are ignored.

Test Plan:
- Reset: assert rst_n=0 mid-DATA of a write -> pin_uio=0, pin_ui=0, req_ready=1 asynchronously; no rsp_valid after release.
- Write: addr=0x12, wdata=0xA5, GAP_CYCLES=1 -> strobes 0x92 then 0xA5 with one gap cycle between. Model acks 2 cycles later -> rsp_valid with rsp_err=0, rsp_rdata=0.
- Read: addr=0x05, model returns uo_out=0x3C with ack -> single strobe byte 0x05; rsp_rdata=0x3C, rsp_err=0.
- Timeout: read with no ack, TIMEOUT=64 -> rsp_valid exactly 64 WAIT cycles after entering WAIT; rsp_err=1, rsp_rdata=0.
- Ack gating: ack with uio_oe[0]=0 -> ignored, transaction times out. Ack coinciding with the last timeout cycle -> rsp_err=0.
- Parity (macro defined): strobe of 0x07 -> pin_uio[1]=1. Read response 0x03 with parity bit 1 -> timeout error; with parity bit 0 -> rsp_rdata=0x03.
